btn_event: RTL and testbench

BTN_EVENT -- requirements
Module: btn_event

---
 rtl/btn_event_pkg.sv | 13 +
 rtl/btn_chan.sv | 116 +++++++++++
 rtl/btn_event.sv | 52 +++++
 tb/tb_btn_event.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/btn_event_pkg.sv
// Shared types for the button event block.
// Channel FSM states and tick counter width.
package btn_event_pkg;

    localparam int CNT_W = 10;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } state_e;

endpackage

// File: rtl/btn_chan.sv
// One button channel: 3-flop synchronizer, edge detect,
// and press/hold/repeat FSM with registered event pulses.
module btn_chan #(
    parameter int LONG_MS   = 500,
    parameter int REPEAT_MS = 100
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic pb_i,
    output logic held_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic repeat_o
);
    import btn_event_pkg::*;

    localparam logic [CNT_W-1:0] LONG_END = CNT_W'(LONG_MS - 1);
    localparam logic [CNT_W-1:0] REP_END  = CNT_W'(REPEAT_MS - 1);

    logic             s1_q, s2_q, s3_q;
    logic             rise, fall;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;
    logic             rel_q, rel_d;
    logic             long_q, long_d;
    logic             rep_q, rep_d;

    assign rise = s2_q & ~s3_q;
    assign fall = ~s2_q & s3_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            long_q  <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            s1_q    <= pb_i;
            s2_q    <= s1_q;
            s3_q    <= s2_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
            rep_q   <= rep_d;
        end
    end

    // A release edge is checked before the tick so it wins a tie.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        rel_d   = 1'b0;
        long_d  = 1'b0;
        rep_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HOLD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                end
            end
            HOLD: begin
                if (fall) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                end else if (tick_i) begin
                    if (cnt_q == LONG_END) begin
                        state_d = REPEAT;
                        cnt_d   = '0;
                        long_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            REPEAT: begin
                if (fall) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                end else if (tick_i) begin
                    if (cnt_q == REP_END) begin
                        cnt_d = '0;
                        rep_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign held_o    = s3_q;
    assign press_o   = press_q;
    assign release_o = rel_q;
    assign long_o    = long_q;
    assign repeat_o  = rep_q;

endmodule

// File: rtl/btn_event.sv
// Button event generator: shared 1 ms prescaler feeding
// N_BTN independent press/long/repeat channels.
module btn_event #(
    parameter int N_BTN      = 4,
    parameter int CLK_PER_MS = 25000,
    parameter int LONG_MS    = 500,
    parameter int REPEAT_MS  = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_BTN-1:0] pb,
    output logic [N_BTN-1:0] held,
    output logic [N_BTN-1:0] press_p,
    output logic [N_BTN-1:0] release_p,
    output logic [N_BTN-1:0] long_p,
    output logic [N_BTN-1:0] repeat_p
);
    localparam int PW = $clog2(CLK_PER_MS);
    localparam logic [PW-1:0] PRE_END = PW'(CLK_PER_MS - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic          tick;

    assign tick    = (presc_q == PRE_END);
    assign presc_d = tick ? '0 : presc_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_chan
        btn_chan #(
            .LONG_MS  (LONG_MS),
            .REPEAT_MS(REPEAT_MS)
        ) u_chan (
            .clk_i    (clk),
            .rst_ni   (rst_n),
            .tick_i   (tick),
            .pb_i     (pb[i]),
            .held_o   (held[i]),
            .press_o  (press_p[i]),
            .release_o(release_p[i]),
            .long_o   (long_p[i]),
            .repeat_o (repeat_p[i])
        );
    end

endmodule

// File: tb/tb_btn_event.sv
// Directed and randomized checks for btn_event with a 4-cycle tick,
// 3-tick long press and 2-tick repeat period.
module tb_btn_event;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] pb = '0;
    logic [N-1:0] held, press_p, release_p, long_p, repeat_p;

    btn_event #(
        .N_BTN     (N),
        .CLK_PER_MS(4),
        .LONG_MS   (3),
        .REPEAT_MS (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pb       (pb),
        .held     (held),
        .press_p  (press_p),
        .release_p(release_p),
        .long_p   (long_p),
        .repeat_p (repeat_p)
    );

    always #5 clk = ~clk;

    typedef struct {
        int ch;
        int hold;
        int press_c;
        int rel_c;
        int long_c;
        int nrep;
        int rep_c;
    } vec_t;

    vec_t vecs[6];

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int press_c[N];
    int rel_c[N];
    int long_c[N];
    int rep_c[N];
    int nrep[N];
    int nevt[N];
    logic [N-1:0] prev_held;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s (cycle %0d): got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    task automatic clear();
        for (int i = 0; i < N; i++) begin
            press_c[i] = 0;
            rel_c[i]   = 0;
            long_c[i]  = 0;
            rep_c[i]   = 0;
            nrep[i]    = 0;
            nevt[i]    = 0;
        end
        prev_held = held;
    endtask

    task automatic record();
        logic [3:0] ev;
        for (int i = 0; i < N; i++) begin
            ev = {press_p[i], release_p[i], long_p[i], repeat_p[i]};
            chk("one_event_per_cycle", int'($onehot0(ev)), 1);
            chk("press_vs_held", int'(press_p[i]), int'(held[i] & ~prev_held[i]));
            chk("release_vs_held", int'(release_p[i]), int'(~held[i] & prev_held[i]));
            if (press_p[i] && press_c[i] == 0) press_c[i] = cyc;
            if (release_p[i] && rel_c[i] == 0) rel_c[i] = cyc;
            if (long_p[i] && long_c[i] == 0) long_c[i] = cyc;
            if (repeat_p[i]) begin
                nrep[i]++;
                if (rep_c[i] == 0) rep_c[i] = cyc;
            end
            nevt[i] += $countones(ev);
        end
        prev_held = held;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        record();
    endtask

    // Reset is released just after an edge; that edge is cycle 0.
    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_held", int'(held), 0);
        chk("reset_pulses", int'(press_p | release_p | long_p | repeat_p), 0);
        rst_n = 1'b1;
        cyc = 0;
        clear();
    endtask

    initial begin
        int others;

        // pb[ch] rises after cycle 1 and falls after cycle 1+hold.
        vecs[0] = '{ch: 0, hold: 2,  press_c: 4, rel_c: 6,  long_c: 0,  nrep: 0, rep_c: 0};
        vecs[1] = '{ch: 1, hold: 40, press_c: 4, rel_c: 44, long_c: 16, nrep: 3, rep_c: 24};
        vecs[2] = '{ch: 2, hold: 12, press_c: 4, rel_c: 16, long_c: 0,  nrep: 0, rep_c: 0};
        vecs[3] = '{ch: 3, hold: 13, press_c: 4, rel_c: 17, long_c: 16, nrep: 0, rep_c: 0};
        vecs[4] = '{ch: 2, hold: 20, press_c: 4, rel_c: 24, long_c: 16, nrep: 0, rep_c: 0};
        vecs[5] = '{ch: 0, hold: 1,  press_c: 4, rel_c: 5,  long_c: 0,  nrep: 0, rep_c: 0};

        for (int v = 0; v < 6; v++) begin
            pb = '0;
            do_reset();
            for (int k = 0; k < 60; k++) begin
                step();
                if (cyc == vecs[v].press_c)
                    chk("held_at_press", int'(held[vecs[v].ch]), 1);
                if (cyc == 1) pb[vecs[v].ch] = 1'b1;
                if (cyc == 1 + vecs[v].hold) pb[vecs[v].ch] = 1'b0;
            end
            chk($sformatf("v%0d_press_cycle", v), press_c[vecs[v].ch], vecs[v].press_c);
            chk($sformatf("v%0d_release_cycle", v), rel_c[vecs[v].ch], vecs[v].rel_c);
            chk($sformatf("v%0d_long_cycle", v), long_c[vecs[v].ch], vecs[v].long_c);
            chk($sformatf("v%0d_repeat_count", v), nrep[vecs[v].ch], vecs[v].nrep);
            chk($sformatf("v%0d_first_repeat", v), rep_c[vecs[v].ch], vecs[v].rep_c);
            others = 0;
            for (int i = 0; i < N; i++)
                if (i != vecs[v].ch) others += nevt[i];
            chk($sformatf("v%0d_other_channels_quiet", v), others, 0);
        end

        // Simultaneous press on 0 and 3, staggered releases.
        pb = '0;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            step();
            if (cyc == 1) pb = 4'b1001;
            if (cyc == 5) pb[0] = 1'b0;
            if (cyc == 9) pb[3] = 1'b0;
        end
        chk("dual_press_ch0", press_c[0], 4);
        chk("dual_press_ch3", press_c[3], 4);
        chk("dual_release_ch0", rel_c[0], 8);
        chk("dual_release_ch3", rel_c[3], 12);
        chk("dual_quiet_ch1_ch2", nevt[1] + nevt[2], 0);

        // Reset mid-REPEAT with the button still held.
        pb = '0;
        do_reset();
        for (int k = 0; k < 26; k++) begin
            step();
            if (cyc == 1) pb[1] = 1'b1;
        end
        chk("pre_reset_long", long_c[1], 16);
        chk("pre_reset_repeat", rep_c[1], 24);
        rst_n = 1'b0;
        #1;
        chk("async_reset_held", int'(held), 0);
        chk("async_reset_pulses", int'(press_p | release_p | long_p | repeat_p), 0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("in_reset_no_release", int'(release_p), 0);
        end
        rst_n = 1'b1;
        cyc = 0;
        clear();
        for (int k = 0; k < 10; k++) step();
        chk("post_reset_press", press_c[1], 3);
        chk("post_reset_no_release", rel_c[1], 0);
        chk("post_reset_held", int'(held[1]), 1);

        // Random activity; per-cycle checks live in record().
        pb = '0;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            step();
            if ($urandom_range(0, 3) == 0) pb = 4'($urandom_range(0, 15));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
